loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 5, width of state/config table address (smart_ptr).
REQ-002 Parameter: ITR_W, default 32, width of each loop counter and bound.
REQ-003 Parameter: DRAIN_CYC, default 4, cycles waited after the last beat before done (PE pipeline latency); range 0..255.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  single-cycle pulse; launches a loop nest.
REQ-007 abort  in  1  single-cycle pulse; terminates the nest.
REQ-008 cfg_base  in  ADDR_W  first state-table entry of the loop body.
REQ-009 cfg_nstate  in  ADDR_W  entries per loop body.
REQ-010 cfg_bound_i / cfg_bound_j / cfg_bound_k  in  ITR_W each  outer, middle and inner trip counts.
REQ-011 stall  in  1  downstream backpressure.
REQ-012 smart_ptr  out  ADDR_W  table read address for the current beat.
REQ-013 itr_i / itr_j / itr_k  out  ITR_W each  current loop indices.
REQ-014 valid  out  1  smart_ptr/itr_* hold a beat.
REQ-015 busy  out  1  high in every state other than IDLE.
REQ-016 done  out  1  single-cycle completion pulse.
REQ-017 err  out  1  single-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE, start with cfg_nstate, cfg_bound_i, cfg_bound_j and cfg_bound_k all nonzero SHALL latch all cfg_* inputs and enter RUN.
REQ-020 In IDLE, start with any of those four fields equal to zero SHALL pulse err on the next cycle and remain in IDLE.
REQ-021 start SHALL be ignored outside IDLE, and cfg_* changes after the start cycle SHALL have no effect.
REQ-022 The first beat SHALL appear on the cycle after start: valid=1, smart_ptr=cfg_base, and itr_i, itr_j, itr_k all 0.
REQ-023 A beat is consumed on a cycle where valid=1 and stall=0; smart_ptr, itr_*, valid and the FSM state SHALL hold while stall=1.
REQ-024 Beat order, innermost first: state offset s (0..nstate-1), then itr_k, then itr_j, then itr_i; smart_ptr = cfg_base+s, modulo 2^ADDR_W (wraps).
REQ-025 Consuming the beat with s=nstate-1 SHALL reset s to 0 and increment itr_k; itr_k reaching bound_k SHALL reset it to 0 and increment itr_j; itr_j likewise increments itr_i.
REQ-026 An unstalled nest SHALL emit exactly nstate*bound_k*bound_j*bound_i consecutive valid beats, with no bubbles.
REQ-027 Consuming the final beat (all indices at maximum) SHALL enter DRAIN with valid=0; DRAIN SHALL last DRAIN_CYC cycles and then enter DONE.
REQ-028 When DRAIN_CYC=0, the final beat SHALL go directly to DONE.
REQ-029 DONE SHALL last one cycle with done=1 and return to IDLE; stall SHALL be ignored in DRAIN and DONE.
REQ-030 abort in any non-IDLE state SHALL return to IDLE on the next edge with valid=0, without asserting done; abort in IDLE SHALL be ignored.
REQ-031 When abort and start coincide in IDLE, start SHALL win.
REQ-032 In IDLE, smart_ptr and itr_* SHALL be 0.
REQ-033 Counter arithmetic SHALL be unsigned, with comparisons against latched bound-1; the maximum bound (2^ITR_W-1) SHALL be supported without overflow.

Reset
REQ-034 While rst=0 at an edge: state=IDLE; valid, busy, done and err = 0; smart_ptr and itr_* = 0; latched configuration cleared.
REQ-035 Reset mid-RUN or mid-DRAIN SHALL discard the nest with no done pulse; the first start after rst returns high SHALL be accepted normally.

Configuration
REQ-036 Macro LOOP_SEQ_PERF_EN, when defined, SHALL add two outputs, run_cycles and stall_cycles (each 32 bits).
REQ-037 run_cycles SHALL count cycles spent in RUN and stall_cycles SHALL count RUN cycles with stall=1; both SHALL clear on accepted start and on reset, saturate at all-ones, and hold after done.
REQ-038 Without LOOP_SEQ_PERF_EN, these ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 base=3, nstate=2, bounds i=1 j=1 k=3, no stall -> 6 beats with ptr 3,4,3,4,3,4 and itr_k 0,0,1,1,2,2; done exactly DRAIN_CYC+1 cycles after the last beat.
REQ-040 base=30, nstate=4, ADDR_W=5 -> smart_ptr sequence 30,31,0,1 repeats per body.
REQ-041 Bounds i=2 j=2 k=2, nstate=1, stall=1 for 3 cycles on beat 5 -> beat 5 (i=1,j=0,k=0) is held for 4 cycles, 8 beats total, and no beat is lost or duplicated.
REQ-042 start with bound_j=0 -> err pulse one cycle later, busy stays 0, no valid.
REQ-043 abort during beat 3 of a 12-beat nest -> valid=0 and busy=0 next cycle, no done; the next start runs a full nest correctly.
REQ-044 rst=0 during DRAIN -> all outputs 0 next cycle; with LOOP_SEQ_PERF_EN, run_cycles equals beats plus stall cycles for an uninterrupted nest.

Source files
------------

// File: rtl/loop_sequencer.sv
// ============================================================================
// Module      : loop_sequencer
// Description : Three-level loop-nest sequencer. Walks a state-table body of
//               cfg_nstate entries (base cfg_base) for every point of an
//               i/j/k iteration space and emits one beat per table entry,
//               honouring downstream stall, then drains the PE pipeline for
//               DRAIN_CYC cycles before pulsing done.
//               Optional macro LOOP_SEQ_PERF_EN adds run_cycles and
//               stall_cycles performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loop_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int ITR_W     = 32,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_nstate,
  input  logic [ITR_W-1:0]  cfg_bound_i,
  input  logic [ITR_W-1:0]  cfg_bound_j,
  input  logic [ITR_W-1:0]  cfg_bound_k,
  input  logic              stall,
  output logic [ADDR_W-1:0] smart_ptr,
  output logic [ITR_W-1:0]  itr_i,
  output logic [ITR_W-1:0]  itr_j,
  output logic [ITR_W-1:0]  itr_k,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef LOOP_SEQ_PERF_EN
  ,
  output logic [31:0]       run_cycles,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ITR_W-1:0]  ITR_ONE    = {{(ITR_W-1){1'b0}}, 1'b1};
  // Drain counter is loaded with DRAIN_CYC-1 and counts down to zero.
  localparam logic [7:0]        DRAIN_LAST = (DRAIN_CYC > 0) ? 8'(DRAIN_CYC - 1) : 8'd0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_s_q, last_s_d;
  logic [ITR_W-1:0]  last_i_q, last_i_d;
  logic [ITR_W-1:0]  last_j_q, last_j_d;
  logic [ITR_W-1:0]  last_k_q, last_k_d;
  logic [ADDR_W-1:0] s_q, s_d;
  logic [ITR_W-1:0]  i_q, i_d;
  logic [ITR_W-1:0]  j_q, j_d;
  logic [ITR_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        drain_q, drain_d;
`ifdef LOOP_SEQ_PERF_EN
  logic [31:0]       run_q, run_d;
  logic [31:0]       stl_q, stl_d;
`endif

  logic cfg_ok;
  logic last_beat;

  // A start is only legal when every trip count and the body length are nonzero.
  assign cfg_ok    = (cfg_nstate != '0) && (cfg_bound_i != '0) &&
                     (cfg_bound_j != '0) && (cfg_bound_k != '0);
  // Comparing against latched bound-1 keeps the maximum bound overflow-free.
  assign last_beat = (s_q == last_s_q) && (k_q == last_k_q) &&
                     (j_q == last_j_q) && (i_q == last_i_q);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    last_s_d = last_s_q;
    last_i_d = last_i_q;
    last_j_d = last_j_q;
    last_k_d = last_k_q;
    s_d      = s_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    drain_d  = drain_q;
`ifdef LOOP_SEQ_PERF_EN
    run_d    = run_q;
    stl_d    = stl_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here, so a coincident start always wins.
        if (start) begin
          if (cfg_ok) begin
            state_d  = ST_RUN;
            base_d   = cfg_base;
            last_s_d = cfg_nstate - ADDR_ONE;
            last_i_d = cfg_bound_i - ITR_ONE;
            last_j_d = cfg_bound_j - ITR_ONE;
            last_k_d = cfg_bound_k - ITR_ONE;
            s_d      = '0;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            ptr_d    = cfg_base;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
`ifdef LOOP_SEQ_PERF_EN
            run_d    = '0;
            stl_d    = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
`ifdef LOOP_SEQ_PERF_EN
        if (run_q != '1) run_d = run_q + 32'd1;
        if (stall && (stl_q != '1)) stl_d = stl_q + 32'd1;
`endif
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          s_d     = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          ptr_d   = '0;
        end else if (!stall) begin
          if (last_beat) begin
            valid_d = 1'b0;
            s_d     = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            ptr_d   = '0;
            if (DRAIN_CYC == 0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_LAST;
            end
          end else begin
            // Innermost first: table offset, then k, then j, then i.
            if (s_q == last_s_q) begin
              s_d = '0;
              if (k_q == last_k_q) begin
                k_d = '0;
                if (j_q == last_j_q) begin
                  j_d = '0;
                  i_d = i_q + ITR_ONE;
                end else begin
                  j_d = j_q + ITR_ONE;
                end
              end else begin
                k_d = k_q + ITR_ONE;
              end
            end else begin
              s_d = s_q + ADDR_ONE;
            end
            ptr_d = base_q + s_d;
          end
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (drain_q == 8'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      last_s_q <= '0;
      last_i_q <= '0;
      last_j_q <= '0;
      last_k_q <= '0;
      s_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      drain_q  <= '0;
`ifdef LOOP_SEQ_PERF_EN
      run_q    <= '0;
      stl_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      last_s_q <= last_s_d;
      last_i_q <= last_i_d;
      last_j_q <= last_j_d;
      last_k_q <= last_k_d;
      s_q      <= s_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
`ifdef LOOP_SEQ_PERF_EN
      run_q    <= run_d;
      stl_q    <= stl_d;
`endif
    end
  end

  assign smart_ptr = ptr_q;
  assign itr_i     = i_q;
  assign itr_j     = j_q;
  assign itr_k     = k_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef LOOP_SEQ_PERF_EN
  assign run_cycles   = run_q;
  assign stall_cycles = stl_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_loop_sequencer.sv
// ============================================================================
// Module      : tb_loop_sequencer
// Description : Self-checking bench for loop_sequencer. A queue of expected
//               beats is generated from plain nested loops; a per-cycle check
//               compares the DUT against it, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_loop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  cfg_base = '0;
  logic [4:0]  cfg_nstate = '0;
  logic [31:0] cfg_bound_i = '0;
  logic [31:0] cfg_bound_j = '0;
  logic [31:0] cfg_bound_k = '0;
  logic        stall = 1'b0;
  logic [4:0]  smart_ptr;
  logic [31:0] itr_i, itr_j, itr_k;
  logic        valid, busy, done, err;
`ifdef LOOP_SEQ_PERF_EN
  logic [31:0] run_cycles, stall_cycles;
`endif

  loop_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_base    (cfg_base),
    .cfg_nstate  (cfg_nstate),
    .cfg_bound_i (cfg_bound_i),
    .cfg_bound_j (cfg_bound_j),
    .cfg_bound_k (cfg_bound_k),
    .stall       (stall),
    .smart_ptr   (smart_ptr),
    .itr_i       (itr_i),
    .itr_j       (itr_j),
    .itr_k       (itr_k),
    .valid       (valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef LOOP_SEQ_PERF_EN
    ,
    .run_cycles  (run_cycles),
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  localparam int DRAIN = 4;

  typedef struct {
    logic [4:0]  ptr;
    logic [31:0] i;
    logic [31:0] j;
    logic [31:0] k;
  } beat_t;

  beat_t q[$];
  int    ptr_log[$];
  int    k_log[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    phase = 0;       // 0 idle, 1 emitting beats, 2 draining/done
  int    drain_left = 0;
  int    pops = 0;
  int    hold = 0;
  int    last_cyc = 0;
  int    done_cyc = 0;
  bit    exp_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beat order from the nest definition, capped for huge bounds.
  task automatic build(input int base, input int nst, input longint bi,
                       input longint bj, input longint bk, input int cap);
    q.delete();
    for (longint i = 0; i < bi; i++)
      for (longint j = 0; j < bj; j++)
        for (longint k = 0; k < bk; k++)
          for (int s = 0; s < nst; s++) begin
            beat_t b;
            if (q.size() >= cap) return;
            b.ptr = 5'((base + s) % 32);
            b.i = 32'(i);
            b.j = 32'(j);
            b.k = 32'(k);
            q.push_back(b);
          end
  endtask

  task automatic check();
    cyc++;
    chk("err", {63'd0, err}, {63'd0, exp_err});
    exp_err = 1'b0;
    if (phase == 1 && q.size() == 0) phase = 0;
    case (phase)
      0: begin
        chk("idle_valid", {63'd0, valid}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_done", {63'd0, done}, 64'd0);
        chk("idle_ptr", {59'd0, smart_ptr}, 64'd0);
        chk("idle_itr", {itr_i, itr_j | itr_k}, 64'd0);
      end
      1: begin
        chk("beat_valid", {63'd0, valid}, 64'd1);
        chk("beat_busy", {63'd0, busy}, 64'd1);
        chk("beat_done", {63'd0, done}, 64'd0);
        chk("beat_ptr", {59'd0, smart_ptr}, {59'd0, q[0].ptr});
        chk("beat_i", {32'd0, itr_i}, {32'd0, q[0].i});
        chk("beat_j", {32'd0, itr_j}, {32'd0, q[0].j});
        chk("beat_k", {32'd0, itr_k}, {32'd0, q[0].k});
        if (valid && itr_i == 1 && itr_j == 0 && itr_k == 0) hold++;
        if (!stall) begin
          ptr_log.push_back(int'(smart_ptr));
          k_log.push_back(int'(itr_k));
          void'(q.pop_front());
          pops++;
          if (q.size() == 0) begin
            phase = 2;
            drain_left = DRAIN;
            last_cyc = cyc;
          end
        end
      end
      default: begin
        chk("drain_valid", {63'd0, valid}, 64'd0);
        chk("drain_busy", {63'd0, busy}, 64'd1);
        if (drain_left > 0) begin
          chk("drain_done", {63'd0, done}, 64'd0);
          drain_left--;
        end else begin
          chk("done_pulse", {63'd0, done}, 64'd1);
          done_cyc = cyc;
          phase = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int base, input int nst, input longint bi,
                        input longint bj, input longint bk);
    cfg_base = 5'(base);
    cfg_nstate = 5'(nst);
    cfg_bound_i = 32'(bi);
    cfg_bound_j = 32'(bj);
    cfg_bound_k = 32'(bk);
    start = 1'b1;
    step();
    start = 1'b0;
    // Later cfg changes must not disturb the running nest.
    cfg_base = 5'd17;
    cfg_nstate = 5'd9;
    cfg_bound_i = 32'd7;
    cfg_bound_j = 32'd5;
    cfg_bound_k = 32'd6;
    if (nst == 0 || bi == 0 || bj == 0 || bk == 0) begin
      exp_err = 1'b1;
    end else begin
      build(base, nst, bi, bj, bk, 64);
      phase = 1;
      pops = 0;
      hold = 0;
      ptr_log.delete();
      k_log.delete();
    end
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while (phase != 0 && n < maxc) begin
      step();
      n++;
    end
    if (phase != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: phase %0d after %0d cycles, required 0", phase, maxc);
    end
  endtask

  task automatic go_model_idle();
    phase = 0;
    q.delete();
  endtask

  initial begin
    int exp_ptr_a[6];
    int exp_k_a[6];
    int exp_ptr_b[4];
    int n;
    exp_ptr_a = '{3, 4, 3, 4, 3, 4};
    exp_k_a   = '{0, 0, 1, 1, 2, 2};
    exp_ptr_b = '{30, 31, 0, 1};

    // Reset state.
    step();
    step();
    rst = 1'b1;
    step();

    // abort in IDLE is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Basic nest: base 3, nstate 2, k=3; a stray start mid-run is ignored.
    launch(3, 2, 1, 1, 3);
    step();
    cfg_bound_k = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    run_idle(40);
    chk("a_beats", 64'(ptr_log.size()), 64'd6);
    for (int x = 0; x < 6 && x < ptr_log.size(); x++) begin
      chk("a_ptr_lit", 64'(ptr_log[x]), 64'(exp_ptr_a[x]));
      chk("a_k_lit", 64'(k_log[x]), 64'(exp_k_a[x]));
    end
    chk("a_done_latency", 64'(done_cyc - last_cyc), 64'd5);
`ifdef LOOP_SEQ_PERF_EN
    chk("a_run_cycles", {32'd0, run_cycles}, 64'd6);
    chk("a_stall_cycles", {32'd0, stall_cycles}, 64'd0);
`endif
    step();

    // Address wrap: base 30, nstate 4.
    launch(30, 4, 1, 1, 2);
    run_idle(40);
    for (int x = 0; x < 8 && x < ptr_log.size(); x++)
      chk("b_ptr_wrap", 64'(ptr_log[x]), 64'(exp_ptr_b[x % 4]));

    // Stall for 3 cycles while beat 5 (i=1,j=0,k=0) is presented.
    launch(0, 1, 2, 2, 2);
    n = 0;
    for (int c = 0; c < 60 && phase != 0; c++) begin
      stall = (pops == 4 && n < 3);
      if (stall) n++;
      step();
    end
    stall = 1'b0;
    run_idle(20);
    chk("c_hold_cycles", 64'(hold), 64'd4);
    chk("c_beats", 64'(pops), 64'd8);
`ifdef LOOP_SEQ_PERF_EN
    chk("c_run_cycles", {32'd0, run_cycles}, 64'd11);
    chk("c_stall_cycles", {32'd0, stall_cycles}, 64'd3);
`endif

    // Rejected starts: zero bound_j, then zero nstate.
    launch(0, 2, 1, 0, 1);
    step();
    step();
    launch(0, 0, 1, 1, 1);
    step();

    // abort during beat 3 of a 12-beat nest, then a full rerun.
    launch(5, 3, 1, 2, 2);
    for (int c = 0; c < 20 && pops < 2; c++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    go_model_idle();
    step();
    step();
    launch(5, 3, 1, 2, 2);
    run_idle(40);
    chk("d_rerun_beats", 64'(pops), 64'd12);

    // start coinciding with abort in IDLE: start wins.
    abort = 1'b1;
    launch(1, 1, 1, 1, 2);
    abort = 1'b0;
    run_idle(20);
    chk("e_beats", 64'(pops), 64'd2);

    // Reset during DRAIN discards the nest; next start is accepted.
    launch(0, 1, 1, 1, 2);
    for (int c = 0; c < 20 && phase != 2; c++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    go_model_idle();
    step();
`ifdef LOOP_SEQ_PERF_EN
    chk("f_run_after_rst", {32'd0, run_cycles}, 64'd0);
`endif
    launch(7, 2, 2, 1, 1);
    run_idle(40);
    chk("f_beats", 64'(pops), 64'd4);

    // Maximum inner bound: runs normally until aborted.
    launch(0, 1, 1, 1, 64'hFFFF_FFFF);
    repeat (5) step();
    chk("g_pops", 64'(pops), 64'd5);
    chk("g_itr_k", {32'd0, itr_k}, 64'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    go_model_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
